// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate generator pipeline.
package imm_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_U     = 3'b001,
    IMM_S     = 3'b010,
    IMM_B     = 3'b011,
    IMM_J     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_CSR   = 3'b110,
    IMM_ILL   = 3'b111
  } immsrc_t;

  // Skid buffer occupancy states
  localparam logic [1:0] SB_EMPTY = 2'd0;
  localparam logic [1:0] SB_ONE   = 2'd1;
  localparam logic [1:0] SB_TWO   = 2'd2;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out bus of imm_gen_pipe, plus flush and debug state.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) ();
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_* and out_* sides are independent, and in_ready is registered.
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_immsrc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic [1:0]       dbg_state;

  modport master (
    output flush, in_valid, in_instr, in_immsrc, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_err, dbg_state
  );

  modport slave (
    input  flush, in_valid, in_instr, in_immsrc, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_err, dbg_state
  );
endinterface

// File: rtl/skid_buffer.sv
// Two-entry skid buffer (main + skid) with registered in_ready and flush.
module skid_buffer
  import imm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   dbg_state
);

  logic [1:0]   state, state_nx;
  logic [W-1:0] main_q, skid_q;
  logic         in_fire, out_fire;
  logic         load_main, load_skid, move_skid;

  assign out_valid = (state != SB_EMPTY);
  assign out_data  = main_q;
  assign dbg_state = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign load_main = in_fire & ((state == SB_EMPTY) | ((state == SB_ONE) & out_fire));
  assign load_skid = in_fire & (state == SB_ONE) & ~out_fire;
  assign move_skid = (state == SB_TWO) & out_fire;

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = SB_EMPTY;
    end else begin
      case (state)
        SB_EMPTY: if (in_fire) state_nx = SB_ONE;
        SB_ONE: begin
          if (out_fire && !in_fire)      state_nx = SB_EMPTY;
          else if (!out_fire && in_fire) state_nx = SB_TWO;
        end
        SB_TWO:   if (out_fire) state_nx = SB_ONE;
        default:  state_nx = SB_EMPTY;
      endcase
    end
  end

  // in_ready mirrors "skid will be empty", so it never depends on out_ready combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SB_EMPTY;
      in_ready <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != SB_TWO);
      if (!flush) begin
        if (load_main)      main_q <= in_data;
        else if (move_skid) main_q <= skid_q;
        if (load_skid)      skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate decoder feeding a two-entry skid buffer.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  imm_gen_pipe_if.slave bus
);

  generate
    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  localparam int PW = XLEN + TAG_W + 1;

  logic [31:0]     ins;
  logic [XLEN-1:0] imm;
  logic            err;
  logic [PW-1:0]   pay_in, pay_out;

  assign ins = bus.in_instr;

  // Signed size casts perform the sign extension from instr[31] up to XLEN
  always_comb begin
    imm = '0;
    err = 1'b0;
    case (immsrc_t'(bus.in_immsrc))
      IMM_I: imm = XLEN'($signed(ins[31:20]));
      IMM_U: imm = XLEN'($signed({ins[31:12], 12'b0}));
      IMM_S: imm = XLEN'($signed({ins[31:25], ins[11:7]}));
      IMM_B: imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      IMM_J: imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      IMM_SHAMT: begin
        imm[4:0] = ins[24:20];
        if (XLEN == 64) imm[5] = ins[25];
      end
      IMM_CSR: imm[4:0] = ins[19:15];
      IMM_ILL: err = 1'b1;
      default: err = 1'b1;
    endcase
  end

  assign pay_in = {imm, bus.in_tag, err};

  skid_buffer #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (pay_in),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (pay_out),
    .dbg_state (bus.dbg_state)
  );

  assign bus.out_imm = pay_out[PW-1 -: XLEN];
  assign bus.out_tag = pay_out[TAG_W:1];
  assign bus.out_err = pay_out[0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: 32-bit instance with scoreboard, 64-bit spot checks.
module tb_imm_gen_pipe;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [37:0] exp_q[$];
  logic [37:0] drv_exp;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference decoder for XLEN=32, built from masks and arithmetic shifts
  function automatic logic [31:0] ref_imm32(input logic [31:0] x, input logic [2:0] src);
    logic signed [31:0] sx;
    logic [31:0] r;
    r = '0;
    case (src)
      3'd0: begin sx = $signed(x); sx = sx >>> 20; r = sx; end
      3'd1: r = x & 32'hFFFFF000;
      3'd2: begin sx = $signed(x & 32'hFE000000); sx = sx >>> 20;
                  r = sx; r = r | ((x >> 7) & 32'h1F); end
      3'd3: begin sx = $signed(x & 32'h80000000); sx = sx >>> 19; r = sx;
                  r = r | ((x << 4) & 32'h800) | ((x >> 20) & 32'h7E0) | ((x >> 7) & 32'h1E); end
      3'd4: begin sx = $signed(x & 32'h80000000); sx = sx >>> 11; r = sx;
                  r = r | (x & 32'h000FF000) | ((x >> 9) & 32'h800) | ((x >> 20) & 32'h7FE); end
      3'd5: r = (x >> 20) & 32'h1F;
      3'd6: r = (x >> 15) & 32'h1F;
      default: r = '0;
    endcase
    return r;
  endfunction

  // driver tasks
  task automatic drive(input logic [31:0] instr, input logic [2:0] src, input logic [4:0] tag);
    b32.in_valid  = 1'b1;
    b32.in_instr  = instr;
    b32.in_immsrc = src;
    b32.in_tag    = tag;
    drv_exp = {ref_imm32(instr, src), tag, (src == 3'd7)};
  endtask

  task automatic idle32();
    b32.in_valid  = 1'b0;
    b32.in_instr  = '0;
    b32.in_immsrc = '0;
    b32.in_tag    = '0;
    b32.flush     = 1'b0;
  endtask

  // scoreboard: push on accepted input, pop and compare on each output transfer
  always @(negedge clk) begin
    logic [37:0] e, act;
    if (rst || b32.flush) begin
      exp_q.delete();
    end else begin
      if (b32.out_valid && b32.out_ready) begin
        checks++;
        act = {b32.out_imm, b32.out_tag, b32.out_err};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got imm=%h tag=%h err=%b with nothing expected",
                   b32.out_imm, b32.out_tag, b32.out_err);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL sb_data: got imm=%h tag=%h err=%b, want imm=%h tag=%h err=%b",
                     act[37:6], act[5:1], act[0], e[37:6], e[5:1], e[0]);
          end
        end
      end
      if (b32.in_valid && b32.in_ready) exp_q.push_back(drv_exp);
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({b32.out_valid, b32.in_ready, b32.out_err} !== 3'b000 || b32.out_imm !== 32'h0 ||
        b32.out_tag !== 5'h0 || b32.dbg_state !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b ready=%b imm=%h tag=%h err=%b st=%b, want all zero",
               b32.out_valid, b32.in_ready, b32.out_imm, b32.out_tag, b32.out_err, b32.dbg_state);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", b32.in_ready, b32.out_valid);
    end
  endtask

  task automatic test_formats();
    logic [31:0] t_ins[9];
    logic [2:0]  t_src[9];
    logic [31:0] t_exp[9];
    t_ins = '{32'hFFF00093, 32'hFFDFF06F, 32'h00000463, 32'h123450B7, 32'h00000400,
              32'h80000000, 32'h03F00013, 32'h000F8073, 32'hFFFFFFFF};
    t_src = '{3'd0, 3'd4, 3'd3, 3'd1, 3'd2, 3'd2, 3'd5, 3'd6, 3'd7};
    t_exp = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008, 32'h12345000, 32'h00000008,
              32'hFFFFF800, 32'h0000001F, 32'h0000001F, 32'h00000000};
    b32.out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      drive(t_ins[k], t_src[k], 5'(k + 1));
      @(posedge clk); #1;
      checks++;
      if (b32.out_valid !== 1'b1 || b32.out_imm !== t_exp[k] ||
          b32.out_err !== (t_src[k] == 3'd7) || b32.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL format_%0d: valid=%b imm=%h err=%b ready=%b, want 1 %h %b 1",
                 k, b32.out_valid, b32.out_imm, b32.out_err, b32.in_ready,
                 t_exp[k], (t_src[k] == 3'd7));
      end
    end
    idle32();
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    b32.out_ready = 1'b0;
    drive($urandom, 3'd0, 5'd1);
    @(posedge clk); #1;
    checks++;
    if (b32.out_valid !== 1'b1 || b32.out_tag !== 5'd1 || b32.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_first: valid=%b tag=%0d ready=%b, want 1 1 1", b32.out_valid, b32.out_tag, b32.in_ready);
    end
    drive($urandom, 3'd1, 5'd2);
    @(posedge clk); #1;
    checks++;
    if (b32.in_ready !== 1'b0 || b32.out_tag !== 5'd1) begin
      errors++;
      $display("FAIL bp_full: ready=%b tag=%0d, want 0 1", b32.in_ready, b32.out_tag);
    end
    drive($urandom, 3'd2, 5'd3);
    @(posedge clk); #1;
    checks++;
    if (b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1 || b32.out_tag !== 5'd1) begin
      errors++;
      $display("FAIL bp_hold: ready=%b valid=%b tag=%0d, want 0 1 1", b32.in_ready, b32.out_valid, b32.out_tag);
    end
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (b32.out_valid !== 1'b1 || b32.out_tag !== 5'd2 || b32.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain1: valid=%b tag=%0d ready=%b, want 1 2 1", b32.out_valid, b32.out_tag, b32.in_ready);
    end
    @(posedge clk); #1;
    idle32();
    checks++;
    if (b32.out_valid !== 1'b1 || b32.out_tag !== 5'd3) begin
      errors++;
      $display("FAIL bp_drain2: valid=%b tag=%0d, want 1 3", b32.out_valid, b32.out_tag);
    end
    @(posedge clk); #1;
    checks++;
    if (b32.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: valid=%b, want 0", b32.out_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) != 0) drive($urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      else b32.in_valid = 1'b0;
      b32.out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    idle32();
    b32.out_ready = 1'b1;
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0 || b32.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: pending=%0d valid=%b, want 0 0", exp_q.size(), b32.out_valid);
    end
  endtask

  task automatic test_flush();
    b32.out_ready = 1'b0;
    drive(32'h00100093, 3'd0, 5'd4);
    @(posedge clk); #1;
    drive(32'h00200093, 3'd0, 5'd5);
    @(posedge clk); #1;
    b32.flush = 1'b1;
    drive(32'h00300093, 3'd0, 5'd6);
    @(posedge clk); #1;
    idle32();
    checks++;
    if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full: valid=%b ready=%b, want 0 1", b32.out_valid, b32.in_ready);
    end
    drive(32'h00400093, 3'd0, 5'd7);
    @(posedge clk); #1;
    b32.flush = 1'b1;
    b32.out_ready = 1'b1;
    drive(32'h00500093, 3'd0, 5'd8);
    @(posedge clk); #1;
    idle32();
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      checks++;
      if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL flush_quiet_%0d: valid=%b ready=%b, want 0 1", n, b32.out_valid, b32.in_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    b32.out_ready = 1'b0;
    drive(32'h00700093, 3'd0, 5'd9);
    @(posedge clk); #1;
    drive(32'h00800093, 3'd0, 5'd10);
    @(posedge clk); #1;
    idle32();
    rst = 1'b1;
    #1;
    checks++;
    if ({b32.out_valid, b32.in_ready, b32.out_err} !== 3'b000 || b32.out_imm !== 32'h0 ||
        b32.out_tag !== 5'h0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b ready=%b imm=%h tag=%h err=%b, want all zero",
               b32.out_valid, b32.in_ready, b32.out_imm, b32.out_tag, b32.out_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    b32.out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      checks++;
      if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_after_%0d: valid=%b ready=%b, want 0 1", n, b32.out_valid, b32.in_ready);
      end
    end
  endtask

  task automatic test_xlen64();
    logic [31:0] ins[3];
    logic [2:0]  src[3];
    logic [63:0] exp[3];
    ins = '{32'h80000013, 32'h03F00013, 32'hFFDFF06F};
    src = '{3'd0, 3'd5, 3'd4};
    exp = '{64'hFFFFFFFFFFFFF800, 64'h000000000000003F, 64'hFFFFFFFFFFFFFFFC};
    b64.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b64.in_valid  = 1'b1;
      b64.in_instr  = ins[k];
      b64.in_immsrc = src[k];
      b64.in_tag    = 5'(k + 20);
      @(posedge clk); #1;
      checks++;
      if (b64.out_valid !== 1'b1 || b64.out_imm !== exp[k] || b64.out_tag !== 5'(k + 20) ||
          b64.out_err !== 1'b0) begin
        errors++;
        $display("FAIL x64_%0d: valid=%b imm=%h tag=%0d err=%b, want 1 %h %0d 0",
                 k, b64.out_valid, b64.out_imm, b64.out_tag, b64.out_err, exp[k], k + 20);
      end
    end
    b64.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    idle32();
    b32.out_ready = 1'b0;
    drv_exp       = '0;
    b64.flush     = 1'b0;
    b64.in_valid  = 1'b0;
    b64.in_instr  = '0;
    b64.in_immsrc = '0;
    b64.in_tag    = '0;
    b64.out_ready = 1'b0;
    test_reset();
    test_formats();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    test_xlen64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
